// File: rtl/gftt_lbuf_if.sv
// Pixel stream in / three-line window out bundle for the GFTT line buffer.
interface gftt_lbuf_if #(
  parameter int unsigned AW = 10
);
  logic [AW-1:0] hsize;
  logic          sof;
  logic [7:0]    pix_in;
  logic          pix_vld;
  logic [7:0]    line0;
  logic [7:0]    line1;
  logic [7:0]    line2;
  logic          vin;
  logic          first_smpl;
  logic          last_smpl;

  modport master (
    output hsize, sof, pix_in, pix_vld,
    input  line0, line1, line2, vin, first_smpl, last_smpl
  );

  modport slave (
    input  hsize, sof, pix_in, pix_vld,
    output line0, line1, line2, vin, first_smpl, last_smpl
  );
endinterface

// File: rtl/gftt_lbuf.sv
// Three-line window generator: two rotating line RAMs feeding the Sobel stage.
// Optional macro GFTT_LBUF_FULLFRAME_EN: windows from row 0 with missing rows read as zero.
module gftt_lbuf #(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  gftt_lbuf_if.slave  bus
);
  localparam int unsigned PW = 8;
  localparam int unsigned RW = 2;

  logic [PW-1:0] r_ram_a [WIDTH];
  logic [PW-1:0] r_ram_b [WIDTH];

  logic [AW-1:0] r_col;
  logic [AW-1:0] r_hsize_l;
  logic [RW-1:0] r_row;
  logic          r_sel;

  logic [PW-1:0] r_line0;
  logic [PW-1:0] r_line1;
  logic [PW-1:0] r_line2;
  logic          r_vin;
  logic          r_first;
  logic          r_last;

  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_hs;
  logic [RW-1:0] w_row;
  logic          w_last;
  logic [PW-1:0] w_old;
  logic [PW-1:0] w_new;
  logic [PW-1:0] w_l0;
  logic [PW-1:0] w_l1;
  logic          w_vin;

  // sof restarts the frame on the very pixel that carries it
  always_comb begin
    w_addr = bus.sof ? '0 : r_col;
    w_hs   = bus.sof ? bus.hsize : r_hsize_l;
    w_row  = bus.sof ? '0 : r_row;
    w_last = (w_addr == (w_hs - AW'(1)));
    // r_sel=0: RAM A holds the older line and takes the write
    w_old  = r_sel ? r_ram_b[w_addr] : r_ram_a[w_addr];
    w_new  = r_sel ? r_ram_a[w_addr] : r_ram_b[w_addr];
`ifdef GFTT_LBUF_FULLFRAME_EN
    w_vin  = 1'b1;
    w_l0   = (w_row == RW'(2)) ? w_old : '0;
    w_l1   = (w_row != '0)     ? w_new : '0;
`else
    w_vin  = (w_row == RW'(2));
    w_l0   = w_old;
    w_l1   = w_new;
`endif
  end

  // Line RAM write port; the read happens through the output registers
  always_ff @(posedge clk) begin
    if (bus.pix_vld) begin
      if (r_sel) r_ram_b[w_addr] <= bus.pix_in;
      else       r_ram_a[w_addr] <= bus.pix_in;
    end
  end

  // Column/row counters and line rotation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_hsize_l <= '0;
      r_row     <= '0;
      r_sel     <= 1'b0;
    end else if (bus.pix_vld) begin
      r_hsize_l <= w_hs;
      if (w_last) begin
        r_col <= '0;
        r_row <= (w_row == RW'(2)) ? w_row : w_row + RW'(1);
        r_sel <= ~r_sel;
      end else begin
        r_col <= w_addr + AW'(1);
        r_row <= w_row;
      end
    end
  end

  // Window outputs; lines hold across idle cycles, flags drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line0 <= '0;
      r_line1 <= '0;
      r_line2 <= '0;
      r_vin   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (bus.pix_vld) begin
      r_line0 <= w_l0;
      r_line1 <= w_l1;
      r_line2 <= bus.pix_in;
      r_vin   <= w_vin;
      r_first <= (w_addr == '0);
      r_last  <= w_last;
    end else begin
      r_vin   <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.line0      = r_line0;
  assign bus.line1      = r_line1;
  assign bus.line2      = r_line2;
  assign bus.vin        = r_vin;
  assign bus.first_smpl = r_first;
  assign bus.last_smpl  = r_last;
endmodule

// File: doc/gftt_lbuf.md
# gftt_lbuf

Three-line window generator for the GFTT feature front end. It takes a raster 8-bit pixel stream and produces three vertically aligned pixel columns, plus valid and row-border flags, on every pixel clock. Its outputs feed the Sobel gradient stage directly: line0 is the top row, line1 the centre row, and line2 the bottom, newest row. It holds two line memories that rotate at every end of row.

## Interface
- WIDTH, 640: maximum line width in pixels; sets the depth of each line RAM.
- AW, 10: column address width; requires 2^AW >= WIDTH.
- rst_n  input  1  asynchronous, active-low reset.
- clk  input  1  clock; every register is on posedge clk.
- hsize  input  AW  active line width in pixels; latched on sof; legal range 3..WIDTH.
- sof  input  1  start of frame; coincident with the first pixel (pix_vld=1).
- pix_in  input  8  input pixel.
- pix_vld  input  1  pixel valid.
- line0  output  8  pixel from row r-2 (top).
- line1  output  8  pixel from row r-1 (centre).
- line2  output  8  pixel from row r (bottom, the current input).
- vin  output  1  window column valid.
- first_smpl  output  1  column 0 of the row; qualified by vin.
- last_smpl  output  1  column hsize-1 of the row; qualified by vin.

## Operation
- Reset value of every output and internal register is 0, including the column counter, row counter, RAM select and latched hsize. RAM contents are not reset.
- Column counter col (AW bits):
  - sof&pix_vld: col=1, row=0, hsize is latched.
  - Other pix_vld: col increments.
  - At col==hsize_l-1: col wraps to 0, row increments, and the RAM select bit toggles.
- Row counter row saturates at 2 and only encodes 0, 1, 2+. It clears on sof.
- Line RAMs A and B, WIDTH x 8, with synchronous read.
  - Both RAMs are read at address col on every pix_vld.
  - pix_in is written at address col into the RAM that holds the older line. The access is read-before-write, so line0 sees the old data.
  - After the row wraps, the RAM just written becomes the newer line.
- Outputs are registered one cycle after the accepted pixel:
  - line2 = pix_in.
  - line1 = newer RAM read data.
  - line0 = older RAM read data.
  - first_smpl = (col==0).
  - last_smpl = (col==hsize_l-1).
  - vin = pix_vld & row>=2.
- When pix_vld=0:
  - vin, first_smpl and last_smpl go to 0.
  - line0, line1 and line2 hold their values.
  - No counter, RAM or select bit changes.
- pix_vld must stay continuous within a row, because the downstream shift registers run on every clk. Gaps are legal only between rows and between frames.
- sof in mid-row aborts the frame. The new pixel is treated as column 0, row 0, and stale RAM lines are never flagged valid because row restarts at 0.
- sof with pix_vld=0 is ignored.
- A pixel beyond hsize_l cannot occur, because col wraps at hsize_l-1.

## Timing
- Latency is one clock, from pix_in/pix_vld to line2/vin.
- Throughput is one pixel per clk, with no backpressure.
- The first valid window is the first pixel of input row 2. A frame of H rows produces (H-2)*hsize_l valid columns (without the macro).
- first_smpl and last_smpl have the same latency as vin. The downstream stage delays them alongside its data.
- Asynchronous reset mid-frame forces all outputs to 0 immediately. The next frame must begin with sof.

## Configuration
- GFTT_LBUF_FULLFRAME_EN
- Defined:
  - vin is asserted from input row 0, so every input pixel yields a window.
  - Missing upper rows read as zero: row 0 forces line0=line1=0, and row 1 forces line0=0.
  - Output column count is H*hsize_l.
- Undefined:
  - vin is asserted only from row 2 onward, as described above.
  - No zero forcing logic is compiled in.

## Test plan
- Reset release, hsize=4, sof + a 4x4 ramp with pix = 16*row + col -> vin low for the first 8 pixels. Row 2, col 1 gives line0=1, line1=17, line2=33. Total vin count is 8.
- Row boundary flags, hsize=5 -> first_smpl on col 0 and last_smpl on col 4, each exactly one cycle with vin=1. Wrap 4->0 has no gap.
- Inter-row gap of 3 idle cycles with pix_vld=0 -> vin=0 during the gap and line outputs hold. The next row's windows are still correctly aligned (row 3 window = rows 1, 2, 3).
- sof in mid-row at row 3, col 2 -> the next two rows give vin=0. The third row gives windows from the new frame only, with no stale data.
- Async reset at row 2, col 1 -> all outputs 0 in the same cycle. The following sof frame behaves exactly as the first scenario.
- With GFTT_LBUF_FULLFRAME_EN, 4x4 ramp -> vin=1 for all 16 pixels. Row 0 gives line0=line1=0. Row 1, col 2 gives line0=0, line1=2, line2=18.
